// File: rtl/sram_access_arbiter.sv
// Round-robin owner arbiter in front of the single-port SRAM_Controller.
// Muxes the owner's access onto the controller and tags read data back to its issuer.
module sram_access_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 64,
    parameter int READ_LAT  = 2
) (
    input  logic               Clock_50,
    input  logic               Resetn,
    input  logic               SRAM_ready,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    acc,
    input  logic [NREQ*18-1:0] req_addr,
    input  logic [NREQ-1:0]    req_we_n,
    input  logic [NREQ*16-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [15:0]        rdata,
    output logic [NREQ-1:0]    rdata_valid,
    output logic [17:0]        SRAM_address,
    output logic [15:0]        SRAM_write_data,
    output logic               SRAM_we_n,
    input  logic [15:0]        SRAM_read_data
);

    // state   | meaning
    // S_IDLE  | no owner, arbitrate when ready and any req
    // S_GRANT | owner holds the SRAM, accesses forwarded
    // S_TURN  | one dead cycle between owners, then arbitrate
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t              state, state_nxt;
    logic [IDW-1:0]      owner, owner_nxt;
    logic [IDW-1:0]      rr_ptr, rr_nxt;
    logic [BW-1:0]       burst_cnt, burst_nxt;
    logic [NREQ-1:0]     gnt_nxt;
    logic [17:0]         addr_q;
    logic [15:0]         wdata_q;
    logic                access;
    logic                is_read;
    logic                burst_last;
    logic [2*NREQ-1:0]   req_dbl;
    logic [NREQ-1:0]     req_rot;
    logic                pick_valid;
    logic [IDW-1:0]      pick_id;
    logic [17:0]         addr_arr [NREQ];
    logic [15:0]         wd_arr   [NREQ];
    logic [READ_LAT-1:0] pipe_v;
    logic [IDW-1:0]      pipe_id  [READ_LAT];

    function automatic logic [IDW-1:0] wrap_id(input logic [IDW:0] v);
        if (v >= (IDW+1)'(NREQ))
            return IDW'(v - (IDW+1)'(NREQ));
        return v[IDW-1:0];
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*18 +: 18];
        assign wd_arr[i]   = req_wdata[i*16 +: 16];
    end

    // Rotate so bit 0 is the requester at the RR pointer; lowest set bit wins.
    assign req_dbl = {req, req} >> rr_ptr;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        pick_valid = |req_rot;
        pick_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k])
                pick_id = wrap_id({1'b0, rr_ptr} + (IDW+1)'(k));
        end
    end

    assign access          = (state == S_GRANT) && SRAM_ready && acc[owner];
    assign is_read         = access && req_we_n[owner];
    assign SRAM_address    = access ? addr_arr[owner] : addr_q;
    assign SRAM_write_data = access ? wd_arr[owner]   : wdata_q;
    assign SRAM_we_n       = access ? req_we_n[owner] : 1'b1;
    assign rdata           = SRAM_read_data;
    assign burst_last      = (burst_cnt == BW'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        burst_nxt = burst_cnt;
        gnt_nxt   = gnt;
        case (state)
            S_IDLE, S_TURN: begin
                gnt_nxt   = '0;
                state_nxt = S_IDLE;
                if (SRAM_ready && pick_valid) begin
                    state_nxt = S_GRANT;
                    owner_nxt = pick_id;
                    gnt_nxt   = NREQ'(1) << pick_id;
                    burst_nxt = '0;
                end
            end
            S_GRANT: begin
                burst_nxt = burst_last ? '0 : burst_cnt + BW'(1);
                if (!req[owner] || !SRAM_ready || (burst_last && |(req & ~gnt))) begin
                    state_nxt = S_TURN;
                    gnt_nxt   = '0;
                    rr_nxt    = wrap_id({1'b0, owner} + (IDW+1)'(1));
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= burst_nxt;
            gnt       <= gnt_nxt;
        end
    end

    // Idle cycles keep the last forwarded address/data on the bus.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (access) begin
            addr_q  <= addr_arr[owner];
            wdata_q <= wd_arr[owner];
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            pipe_v <= '0;
            for (int k = 0; k < READ_LAT; k++)
                pipe_id[k] <= '0;
        end else begin
            pipe_v[0]  <= is_read;
            pipe_id[0] <= owner;
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end
        end
    end

    assign rdata_valid = pipe_v[READ_LAT-1] ? (NREQ'(1) << pipe_id[READ_LAT-1]) : '0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter (MAX_BURST=4) with a 2-cycle SRAM model.
module tb_sram_access_arbiter;

    logic        Clock_50 = 1'b0;
    logic        Resetn;
    logic        SRAM_ready;
    logic [2:0]  req, acc, req_we_n;
    logic [53:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  gnt, rdata_valid;
    logic [15:0] rdata, SRAM_write_data, SRAM_read_data;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;

    int checks = 0;
    int errors = 0;

    sram_access_arbiter #(.NREQ(3), .MAX_BURST(4), .READ_LAT(2)) dut (
        .Clock_50(Clock_50), .Resetn(Resetn), .SRAM_ready(SRAM_ready),
        .req(req), .acc(acc), .req_addr(req_addr), .req_we_n(req_we_n),
        .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata), .rdata_valid(rdata_valid),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
    );

    always #5 Clock_50 = ~Clock_50;

    // Controller model: word = addr[15:0]^A5A5 until written; read data valid 2 cycles later.
    logic [15:0] mem [0:262143];
    logic [15:0] rd_pipe;
    initial begin
        for (int a = 0; a < 262144; a++) mem[a] = 16'(a) ^ 16'hA5A5;
        rd_pipe = '0;
        SRAM_read_data = '0;
    end
    always @(posedge Clock_50) begin
        if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
        rd_pipe        <= mem[SRAM_address];
        SRAM_read_data <= rd_pipe;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] a, input logic [2:0] w,
                         input logic [53:0] ad, input logic [47:0] wd);
        req = r; acc = a; req_we_n = w; req_addr = ad; req_wdata = wd;
    endtask

    task automatic do_reset;
        @(negedge Clock_50);
        Resetn = 1'b0;
        SRAM_ready = 1'b0;
        drive(3'b000, 3'b000, 3'b111, '0, '0);
        repeat (2) @(negedge Clock_50);
        Resetn = 1'b1;
        SRAM_ready = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic [2:0]  req, acc, we_n;
        logic [53:0] addr;
        logic [47:0] wd;
        logic [2:0]  e_gnt;
        logic        e_we_n;
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        logic [2:0]  e_rv;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    logic [2:0] exp_g;
    logic [2:0] s3_gnt [7];
    logic [2:0] s3_rv  [7];
    logic [15:0] s3_rd [7];

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 3'b000, 3'b111, {18'd0, 18'd0, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b000, 1'b1, 18'd0, 16'h0000, 3'b000, 16'h0};
        vecs[1]  = '{1'b1, 3'b010, 3'b010, 3'b111, {18'd0, 18'd38400, 18'd0}, {16'h0, 16'h1111, 16'h0},
                     3'b010, 1'b1, 18'd38400, 16'h1111, 3'b000, 16'h0};
        vecs[2]  = '{1'b1, 3'b010, 3'b100, 3'b011, {18'h3FFFF, 18'd38400, 18'd0}, {16'hBEEF, 16'h1111, 16'h0},
                     3'b010, 1'b1, 18'd38400, 16'h1111, 3'b000, 16'h0};
        vecs[3]  = '{1'b1, 3'b010, 3'b010, 3'b101, {18'd0, 18'd100, 18'd0}, {16'h0, 16'h1234, 16'h0},
                     3'b010, 1'b0, 18'd100, 16'h1234, 3'b010, 16'h33A5};
        vecs[4]  = '{1'b1, 3'b010, 3'b010, 3'b111, {18'd0, 18'd100, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b010, 1'b1, 18'd100, 16'h0000, 3'b000, 16'h0};
        vecs[5]  = '{1'b1, 3'b000, 3'b000, 3'b111, {18'd0, 18'd0, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b010, 1'b1, 18'd100, 16'h0000, 3'b000, 16'h0};
        vecs[6]  = '{1'b1, 3'b000, 3'b000, 3'b111, {18'd0, 18'd0, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b000, 1'b1, 18'd100, 16'h0000, 3'b010, 16'h1234};
        vecs[7]  = '{1'b1, 3'b001, 3'b001, 3'b110, {18'd0, 18'd0, 18'd5}, {16'h0, 16'h0, 16'hABCD},
                     3'b000, 1'b1, 18'd100, 16'h0000, 3'b000, 16'h0};
        vecs[8]  = '{1'b1, 3'b001, 3'b001, 3'b110, {18'd0, 18'd0, 18'd5}, {16'h0, 16'h0, 16'hABCD},
                     3'b001, 1'b0, 18'd5, 16'hABCD, 3'b000, 16'h0};
        vecs[9]  = '{1'b1, 3'b000, 3'b000, 3'b111, {18'd0, 18'd0, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b001, 1'b1, 18'd5, 16'hABCD, 3'b000, 16'h0};
        vecs[10] = '{1'b1, 3'b000, 3'b000, 3'b111, {18'd0, 18'd0, 18'd0}, {16'h0, 16'h0, 16'h0},
                     3'b000, 1'b1, 18'd5, 16'hABCD, 3'b000, 16'h0};

        s3_gnt = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100};
        s3_rv  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b100, 3'b100};
        s3_rd  = '{16'h0, 16'h0, 16'h0, 16'hA5A2, 16'h0, 16'hA56D, 16'hA56D};

        Resetn = 1'b1;
        SRAM_ready = 1'b0;
        drive(3'b000, 3'b000, 3'b111, '0, '0);

        // Reset values and basic read / write / hand-back table
        do_reset();
        #1;
        chk("reset_gnt", gnt, 3'b000);
        chk("reset_rv", rdata_valid, 3'b000);
        chk("reset_we_n", SRAM_we_n, 1'b1);
        chk("reset_addr", SRAM_address, 18'd0);
        chk("reset_wdata", SRAM_write_data, 16'h0);
        for (int i = 0; i < 11; i++) begin
            @(negedge Clock_50);
            SRAM_ready = vecs[i].rdy;
            drive(vecs[i].req, vecs[i].acc, vecs[i].we_n, vecs[i].addr, vecs[i].wd);
            #1;
            chk($sformatf("v%0d_gnt", i), gnt, vecs[i].e_gnt);
            chk($sformatf("v%0d_we_n", i), SRAM_we_n, vecs[i].e_we_n);
            chk($sformatf("v%0d_addr", i), SRAM_address, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), SRAM_write_data, vecs[i].e_wd);
            chk($sformatf("v%0d_rv", i), rdata_valid, vecs[i].e_rv);
            if (vecs[i].e_rv != 3'b000)
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
        end

        // Round-robin with burst cap: 4-cycle tenures, 1 dead cycle between
        do_reset();
        for (int c = 0; c < 21; c++) begin
            @(negedge Clock_50);
            drive(3'b111, 3'b111, 3'b000, {18'd1002, 18'd1001, 18'd1000}, {16'h2, 16'h1, 16'h0});
            #1;
            if (c == 0 || ((c - 1) % 5) == 4) exp_g = 3'b000;
            else exp_g = 3'b001 << (((c - 1) / 5) % 3);
            chk($sformatf("rr_c%0d_gnt", c), gnt, exp_g);
            chk($sformatf("rr_c%0d_we_n", c), SRAM_we_n, exp_g == 3'b000);
            if (exp_g != 3'b000)
                chk($sformatf("rr_c%0d_addr", c), SRAM_address, 18'd1000 + 18'(((c - 1) / 5) % 3));
        end

        // Lone requester keeps ownership across burst-counter wraps
        do_reset();
        @(negedge Clock_50);
        drive(3'b010, 3'b000, 3'b111, '0, '0);
        for (int c = 0; c < 200; c++) begin
            @(negedge Clock_50);
            #1;
            chk($sformatf("solo_c%0d_gnt", c), gnt, 3'b010);
        end

        // Read in owner's last cycle delivered after hand-over; new owner's reads later
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge Clock_50);
            if (c == 0) drive(3'b101, 3'b000, 3'b111, '0, '0);
            else if (c == 1) drive(3'b100, 3'b101, 3'b111, {18'd200, 18'd0, 18'd7}, '0);
            else drive(3'b100, 3'b100, 3'b111, {18'd200, 18'd0, 18'd0}, '0);
            #1;
            chk($sformatf("ho_c%0d_gnt", c), gnt, s3_gnt[c]);
            chk($sformatf("ho_c%0d_rv", c), rdata_valid, s3_rv[c]);
            if (s3_rv[c] != 3'b000)
                chk($sformatf("ho_c%0d_rdata", c), rdata, s3_rd[c]);
        end

        // Non-owner write ignored; SRAM_ready low drops the owner
        do_reset();
        @(negedge Clock_50);
        drive(3'b001, 3'b000, 3'b111, '0, '0);
        for (int c = 1; c < 7; c++) begin
            @(negedge Clock_50);
            drive(3'b001, 3'b100, 3'b011, {18'h3FFFF, 18'd0, 18'd0}, {16'hBEEF, 16'h0, 16'h0});
            #1;
            chk($sformatf("nonown_c%0d_gnt", c), gnt, 3'b001);
            chk($sformatf("nonown_c%0d_we_n", c), SRAM_we_n, 1'b1);
            chk($sformatf("nonown_c%0d_wdata", c), SRAM_write_data, 16'h0000);
        end
        @(negedge Clock_50);
        SRAM_ready = 1'b0;
        drive(3'b001, 3'b001, 3'b110, {18'd0, 18'd0, 18'd9}, {16'h0, 16'h0, 16'h7777});
        #1;
        chk("notready_we_n", SRAM_we_n, 1'b1);
        chk("notready_gnt_held", gnt, 3'b001);
        chk("nonown_mem", mem[18'h3FFFF], 16'h5A5A);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock_50);
            #1;
            chk($sformatf("notready_c%0d_gnt", c), gnt, 3'b000);
        end
        @(negedge Clock_50);
        SRAM_ready = 1'b1;
        #1;
        chk("ready_back_gnt0", gnt, 3'b000);
        @(negedge Clock_50);
        #1;
        chk("ready_back_gnt", gnt, 3'b001);
        chk("notready_mem", mem[18'd9], 16'hA5AC);

        // Reset one cycle after a read: no delivery, RR pointer back to 0
        do_reset();
        @(negedge Clock_50);
        drive(3'b001, 3'b000, 3'b111, '0, '0);
        @(negedge Clock_50);
        drive(3'b000, 3'b000, 3'b111, '0, '0);
        @(negedge Clock_50);
        drive(3'b010, 3'b000, 3'b111, '0, '0);
        @(negedge Clock_50);
        drive(3'b010, 3'b010, 3'b111, {18'd0, 18'd300, 18'd0}, '0);
        #1;
        chk("rst_pre_gnt", gnt, 3'b010);
        @(negedge Clock_50);
        drive(3'b010, 3'b010, 3'b101, {18'd0, 18'd301, 18'd0}, {16'h0, 16'hDEAD, 16'h0});
        Resetn = 1'b0;
        #1;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_we_n", SRAM_we_n, 1'b1);
        @(negedge Clock_50);
        Resetn = 1'b1;
        drive(3'b000, 3'b000, 3'b111, '0, '0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rst_c%0d_rv", c), rdata_valid, 3'b000);
            @(negedge Clock_50);
        end
        drive(3'b011, 3'b000, 3'b111, '0, '0);
        @(negedge Clock_50);
        #1;
        chk("rst_rr_gnt", gnt, 3'b001);
        chk("rst_mem", mem[18'd301], 16'hA488);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
